// File: rtl/weather_alarm.sv
// Per-room weather alarm: qualifies the rain detector with two-sample hysteresis
// and registers occupied/unoccupied open-window alerts while the weather is bad.
module weather_alarm (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] humanDetector,
   input  logic [7:0] windowState,
   input  logic       rain_sensor,
   input  logic [2:0] humidity_level,
   input  logic [3:0] external_temp,
   output logic [7:0] weather_alert,
   output logic [7:0] window_close_cmd
);

   logic rain_d;
   logic rain_q;
   logic humid;
   logic cold;
   logic bad_weather;

   always_comb begin
      humid       = (humidity_level >= 3'd6);
      cold        = (external_temp <= 4'd2);
      bad_weather = rain_q | humid | cold;
   end

   // rain_q only moves when the current and previous samples agree, so a
   // single-cycle glitch in either direction leaves it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rain_d           <= 1'b0;
         rain_q           <= 1'b0;
         weather_alert    <= 8'h00;
         window_close_cmd <= 8'h00;
      end else begin
         rain_d <= rain_sensor;
         if (rain_sensor && rain_d)
            rain_q <= 1'b1;
         else if (!rain_sensor && !rain_d)
            rain_q <= 1'b0;
         weather_alert    <= {8{bad_weather}} & windowState &  humanDetector;
         window_close_cmd <= {8{bad_weather}} & windowState & ~humanDetector;
      end
   end

endmodule

// File: tb/tb_weather_alarm.sv
// Self-checking bench for weather_alarm: directed scenarios plus randomized
// stimulus compared against a run-length based behavioural model.
module tb_weather_alarm;

   logic       clk;
   logic       rst;
   logic [7:0] humanDetector;
   logic [7:0] windowState;
   logic       rain_sensor;
   logic [2:0] humidity_level;
   logic [3:0] external_temp;
   logic [7:0] weather_alert;
   logic [7:0] window_close_cmd;

   int total;
   int bad;

   // Reference model state: rain flag plus lengths of current sample runs.
   bit       m_rain;
   int       m_ones;
   int       m_zeros;
   bit [7:0] exp_alert;
   bit [7:0] exp_close;

   weather_alarm dut (
      .clk              (clk),
      .rst              (rst),
      .humanDetector    (humanDetector),
      .windowState      (windowState),
      .rain_sensor      (rain_sensor),
      .humidity_level   (humidity_level),
      .external_temp    (external_temp),
      .weather_alert    (weather_alert),
      .window_close_cmd (window_close_cmd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_rain    = 1'b0;
      m_ones    = 0;
      m_zeros   = 0;
      exp_alert = 8'h00;
      exp_close = 8'h00;
   endtask

   // One clock: predict the registered outputs from pre-edge inputs, then
   // fold the sampled rain value into the hysteresis model.
   task automatic tick();
      bit weather_bad;
      weather_bad = m_rain || (int'(humidity_level) >= 6) || (int'(external_temp) <= 2);
      exp_alert = weather_bad ? (windowState & humanDetector)  : 8'h00;
      exp_close = weather_bad ? (windowState & ~humanDetector) : 8'h00;
      @(posedge clk);
      if (rain_sensor) begin
         m_ones++;
         m_zeros = 0;
      end else begin
         m_zeros++;
         m_ones = 0;
      end
      if (m_ones >= 2) m_rain = 1'b1;
      if (m_zeros >= 2) m_rain = 1'b0;
      #1;
   endtask

   task automatic set_inputs(input logic [7:0] hum, input logic [7:0] win, input logic rain,
                             input logic [2:0] humi, input logic [3:0] temp);
      humanDetector  = hum;
      windowState    = win;
      rain_sensor    = rain;
      humidity_level = humi;
      external_temp  = temp;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_inputs(8'hF0, 8'h0F, 1'b0, 3'd7, 4'd9);
      model_reset();
      #3;
      total++;
      if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
         bad++;
         $display("FAIL reset_initial alert=%h close=%h expected 00/00", weather_alert, window_close_cmd);
      end
      @(posedge clk);
      #1;
      total++;
      if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
         bad++;
         $display("FAIL reset_held alert=%h close=%h expected 00/00", weather_alert, window_close_cmd);
      end
      #3;
      rst = 1'b0;
   endtask

   task automatic test_dry();
      set_inputs(8'hF0, 8'h0F, 1'b0, 3'd3, 4'd9);
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
            bad++;
            $display("FAIL dry cyc=%0d alert=%h close=%h expected 00/00", i, weather_alert, window_close_cmd);
         end
      end
   endtask

   task automatic test_rain();
      rain_sensor = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
            bad++;
            $display("FAIL rain_latency edge=%0d alert=%h close=%h expected 00/00", i + 1, weather_alert, window_close_cmd);
         end
      end
      tick();
      total++;
      if (weather_alert !== 8'h00 || window_close_cmd !== 8'h0F) begin
         bad++;
         $display("FAIL rain_on alert=%h close=%h expected 00/0F", weather_alert, window_close_cmd);
      end
   endtask

   task automatic test_window_change();
      windowState = 8'h33;
      tick();
      total++;
      if (weather_alert !== 8'h30 || window_close_cmd !== 8'h03) begin
         bad++;
         $display("FAIL window_change alert=%h close=%h expected 30/03", weather_alert, window_close_cmd);
      end
   endtask

   task automatic test_thresholds();
      set_inputs(8'hAA, 8'hFF, 1'b0, 3'd3, 4'd9);
      repeat (3) tick();
      total++;
      if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
         bad++;
         $display("FAIL rain_clear alert=%h close=%h expected 00/00", weather_alert, window_close_cmd);
      end
      humidity_level = 3'd7;
      tick();
      total++;
      if (weather_alert !== 8'hAA || window_close_cmd !== 8'h55) begin
         bad++;
         $display("FAIL humid7 alert=%h close=%h expected AA/55", weather_alert, window_close_cmd);
      end
      humidity_level = 3'd6;
      tick();
      total++;
      if (weather_alert !== 8'hAA || window_close_cmd !== 8'h55) begin
         bad++;
         $display("FAIL humid6 alert=%h close=%h expected AA/55", weather_alert, window_close_cmd);
      end
      humidity_level = 3'd5;
      external_temp  = 4'd2;
      tick();
      total++;
      if (weather_alert !== 8'hAA || window_close_cmd !== 8'h55) begin
         bad++;
         $display("FAIL temp2 alert=%h close=%h expected AA/55", weather_alert, window_close_cmd);
      end
      external_temp = 4'd3;
      tick();
      total++;
      if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
         bad++;
         $display("FAIL temp3 alert=%h close=%h expected 00/00", weather_alert, window_close_cmd);
      end
   endtask

   task automatic test_glitch();
      set_inputs(8'hAA, 8'hFF, 1'b1, 3'd3, 4'd9);
      tick();
      rain_sensor = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
            bad++;
            $display("FAIL glitch cyc=%0d alert=%h close=%h expected 00/00", i, weather_alert, window_close_cmd);
         end
      end
   endtask

   task automatic test_reset_mid_rain();
      set_inputs(8'hAA, 8'hFF, 1'b1, 3'd3, 4'd9);
      repeat (3) tick();
      total++;
      if (weather_alert !== 8'hAA || window_close_cmd !== 8'h55) begin
         bad++;
         $display("FAIL pre_reset alert=%h close=%h expected AA/55", weather_alert, window_close_cmd);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
         bad++;
         $display("FAIL async_reset alert=%h close=%h expected 00/00", weather_alert, window_close_cmd);
      end
      model_reset();
      @(posedge clk);
      #4;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (weather_alert !== 8'h00 || window_close_cmd !== 8'h00) begin
            bad++;
            $display("FAIL requalify edge=%0d alert=%h close=%h expected 00/00", i + 1, weather_alert, window_close_cmd);
         end
      end
      tick();
      total++;
      if (weather_alert !== 8'hAA || window_close_cmd !== 8'h55) begin
         bad++;
         $display("FAIL requalified alert=%h close=%h expected AA/55", weather_alert, window_close_cmd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         humanDetector  = 8'($urandom);
         windowState    = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rain_sensor = ~rain_sensor;
         humidity_level = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 5));
         external_temp  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(3, 15));
         tick();
         total++;
         if (weather_alert !== exp_alert || window_close_cmd !== exp_close) begin
            bad++;
            $display("FAIL random cyc=%0d alert=%h close=%h expected %h/%h", i, weather_alert, window_close_cmd, exp_alert, exp_close);
         end
         total++;
         if ((weather_alert & window_close_cmd) !== 8'h00) begin
            bad++;
            $display("FAIL exclusive cyc=%0d overlap=%h expected 00", i, weather_alert & window_close_cmd);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_dry();
      test_rain();
      test_window_change();
      test_thresholds();
      test_glitch();
      test_reset_mid_rain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
